// File: rtl/tipi_link_responder_if.sv
// Host register port of the TIPI link responder.
// Data bytes are numbered TI-style: bit 0 is the MSB.
interface tipi_link_responder_if;
    logic [2:0] adr;
    logic       cs;
    logic       we;
    logic [0:7] d;
    logic [0:7] q;

    modport master (output adr, cs, we, d, input q);
    modport slave  (input adr, cs, we, d, output q);
endinterface

// File: rtl/tipi_link_responder.sv
// Pi-side responder of the TIPI serial link.
// It sources the TC/TD bytes the initiator reads and captures the RC/RD bytes
// the initiator writes. A byte-wide host port exposes both pairs plus status.
// All link activity is keyed to rising edges of the synchronized tclk.
module tipi_link_responder (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    tipi_link_responder_if.slave        host,
    input  logic                        tclk,
    input  logic                        rt,
    input  logic                        le,
    input  logic                        dc,
    input  logic                        dout,
    output logic                        din,
    output logic                        treset
);

    localparam logic [2:0] ADR_TC     = 3'd0;
    localparam logic [2:0] ADR_TD     = 3'd1;
    localparam logic [2:0] ADR_RC     = 3'd2;
    localparam logic [2:0] ADR_RD     = 3'd3;
    localparam logic [2:0] ADR_STATUS = 3'd4;

    // Synchronizer layout: {tclk, rt, le, dc, dout}
    logic [4:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic       tclk_prev_q, tclk_prev_d;
    logic       rt_prev_q, rt_prev_d;
    logic [3:0] count_q, count_d;
    logic [7:0] frame_q, frame_d;
    logic       tx_dc_q, tx_dc_d;
    logic [7:0] shift_q, shift_d;
    logic       din_q, din_d;
    logic [7:0] tc_q, tc_d, td_q, td_d, rc_q, rc_d, rd_q, rd_d;
    // flags: {rc_new, rd_new, tc_sent, td_sent}
    logic [3:0] flags_q, flags_d;
    logic       treset_q, treset_d;

    logic       s_tclk, s_rt, s_le, s_dc, s_dout;
    logic       rise;
    logic [3:0] cnt;
    logic [3:0] flag_set, flag_clr;
    logic       host_wr;
    logic [7:0] wdat;
    logic [7:0] rdat;

    assign s_tclk  = sync2_q[4];
    assign s_rt    = sync2_q[3];
    assign s_le    = sync2_q[2];
    assign s_dc    = sync2_q[1];
    assign s_dout  = sync2_q[0];
    assign rise    = s_tclk & ~tclk_prev_q;
    assign host_wr = host.cs & host.we;
    assign wdat    = host.d;

    // Two-stage synchronizer for all asynchronous link lines
    always_comb begin
        sync1_d     = {tclk, rt, le, dc, dout};
        sync2_d     = sync1_q;
        tclk_prev_d = s_tclk;
    end

    // Link engine: one step per synchronized tclk rise
    always_comb begin
        rt_prev_d = rt_prev_q;
        count_d   = count_q;
        frame_d   = frame_q;
        tx_dc_d   = tx_dc_q;
        shift_d   = shift_q;
        din_d     = din_q;
        rc_d      = rc_q;
        rd_d      = rd_q;
        flag_set  = 4'b0000;
        cnt       = count_q;
        if (!enable) begin
            count_d = 4'd0;
            din_d   = 1'b0;
        end else if (rise) begin
            rt_prev_d = s_rt;
            // A direction change drops any partial byte before this edge is used
            cnt = (s_rt != rt_prev_q) ? 4'd0 : count_q;
            if (s_rt) begin
                if (s_le) begin
                    frame_d = s_dc ? td_q : tc_q;
                    tx_dc_d = s_dc;
                    count_d = 4'd0;
                    din_d   = 1'b0;
                    // le rises on both ack and retry, so this only marks completion
                    if (cnt == 4'd9) begin
                        if (tx_dc_q) flag_set[0] = 1'b1;
                        else         flag_set[1] = 1'b1;
                    end
                end else if (cnt < 4'd8) begin
                    din_d   = frame_q[3'd7 - cnt[2:0]];
                    count_d = cnt + 4'd1;
                end else if (cnt == 4'd8) begin
                    din_d   = ^frame_q;
                    count_d = 4'd9;
                end else begin
                    count_d = cnt;
                end
            end else begin
                if (!s_le) begin
                    if (cnt < 4'd8) begin
                        shift_d = {shift_q[6:0], s_dout};
                        count_d = cnt + 4'd1;
                        if (cnt == 4'd7) din_d = ^{shift_q[6:0], s_dout};
                    end else begin
                        // Initiator is resending after a parity reject
                        shift_d = {7'b0000000, s_dout};
                        count_d = 4'd1;
                    end
                end else begin
                    if (cnt == 4'd8) begin
                        if (s_dc) begin
                            rd_d        = shift_q;
                            flag_set[2] = 1'b1;
                        end else begin
                            rc_d        = shift_q;
                            flag_set[3] = 1'b1;
                        end
                    end
                    count_d = 4'd0;
                end
            end
        end
    end

    // Host register writes; a flag set beats a simultaneous w1c
    always_comb begin
        tc_d     = tc_q;
        td_d     = td_q;
        treset_d = treset_q;
        flag_clr = 4'b0000;
        if (host_wr) begin
            case (host.adr)
                ADR_TC:     tc_d = wdat;
                ADR_TD:     td_d = wdat;
                ADR_STATUS: begin
                    flag_clr = wdat[7:4];
                    treset_d = wdat[3];
                end
                default: ;
            endcase
        end
        flags_d = (flags_q & ~flag_clr) | flag_set;
    end

    // Host read mux, combinational from address
    always_comb begin
        rdat = 8'h00;
        case (host.adr)
            ADR_TC:     rdat = tc_q;
            ADR_TD:     rdat = td_q;
            ADR_RC:     rdat = rc_q;
            ADR_RD:     rdat = rd_q;
            ADR_STATUS: rdat = {flags_q, treset_q, 3'b000};
            default:    rdat = 8'h00;
        endcase
    end

    assign host.q = rdat;
    assign din    = din_q;
    assign treset = treset_q;

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= 5'd0;
            sync2_q     <= 5'd0;
            tclk_prev_q <= 1'b0;
            rt_prev_q   <= 1'b0;
            count_q     <= 4'd0;
            frame_q     <= 8'h00;
            tx_dc_q     <= 1'b0;
            shift_q     <= 8'h00;
            din_q       <= 1'b0;
            tc_q        <= 8'h00;
            td_q        <= 8'h00;
            rc_q        <= 8'h00;
            rd_q        <= 8'h00;
            flags_q     <= 4'b0000;
            treset_q    <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            tclk_prev_q <= tclk_prev_d;
            rt_prev_q   <= rt_prev_d;
            count_q     <= count_d;
            frame_q     <= frame_d;
            tx_dc_q     <= tx_dc_d;
            shift_q     <= shift_d;
            din_q       <= din_d;
            tc_q        <= tc_d;
            td_q        <= td_d;
            rc_q        <= rc_d;
            rd_q        <= rd_d;
            flags_q     <= flags_d;
            treset_q    <= treset_d;
        end
    end

endmodule

// File: tb/tb_tipi_link_responder.sv
// Bench for tipi_link_responder: a simple initiator model drives the link,
// expected bytes go into a scoreboard queue and are compared as they appear.
module tb_tipi_link_responder;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic tclk, rt, le, dc, dout;
    logic din, treset;

    tipi_link_responder_if host_if ();

    tipi_link_responder dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .host   (host_if),
        .tclk   (tclk),
        .rt     (rt),
        .le     (le),
        .dc     (dc),
        .dout   (dout),
        .din    (din),
        .treset (treset)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [7:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [7:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 8'(sb_q.size()), 8'd1);
        end else begin
            e = sb_q.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    task automatic host_wr(input logic [2:0] a, input logic [7:0] v);
        @(negedge clk);
        host_if.adr = a;
        host_if.d   = v;
        host_if.cs  = 1'b1;
        host_if.we  = 1'b1;
        @(negedge clk);
        host_if.cs  = 1'b0;
        host_if.we  = 1'b0;
    endtask

    task automatic host_rd(input logic [2:0] a, output logic [7:0] v);
        @(negedge clk);
        host_if.adr = a;
        host_if.cs  = 1'b1;
        host_if.we  = 1'b0;
        #1;
        v = host_if.q;
        host_if.cs  = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [2:0] a, input logic [7:0] exp);
        logic [7:0] v;
        sb_push(tag, exp);
        host_rd(a, v);
        sb_pop(v);
    endtask

    task automatic check_din(input string tag, input logic exp);
        sb_push(tag, {7'b0000000, exp});
        sb_pop({7'b0000000, din});
    endtask

    // One initiator clock: lines set first, tclk high 6 cycles, low 4 cycles
    task automatic pulse(input logic r, input logic l, input logic c, input logic o);
        rt = r; le = l; dc = c; dout = o;
        repeat (2) @(negedge clk);
        tclk = 1'b1;
        repeat (6) @(negedge clk);
        tclk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Initiator read of one frame: le pulse, 8 data bits, parity bit
    task automatic tx_frame(input logic c, output logic [7:0] b, output logic p);
        b = 8'h00;
        pulse(1'b1, 1'b1, c, 1'b0);
        for (int i = 0; i < 8; i++) begin
            pulse(1'b1, 1'b0, c, 1'b0);
            b = {b[6:0], din};
        end
        pulse(1'b1, 1'b0, c, 1'b0);
        p = din;
    endtask

    task automatic rx_bits(input logic c, input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) pulse(1'b0, 1'b0, c, v[7-i]);
    endtask

    task automatic rx_byte_checked(input string tag, input logic c, input logic [7:0] v);
        sb_push(tag, {7'b0000000, ^v});
        rx_bits(c, v, 8);
        sb_pop({7'b0000000, din});
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        logic       p;

        reset = 1'b1; enable = 1'b1;
        tclk = 1'b0; rt = 1'b0; le = 1'b0; dc = 1'b0; dout = 1'b0;
        host_if.adr = 3'd0; host_if.cs = 1'b0; host_if.we = 1'b0; host_if.d = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        for (int a = 0; a < 6; a++) check_reg("reset_reg", 3'(a), 8'h00);
        check_din("reset_din", 1'b0);
        sb_push("reset_treset", 8'h00);
        sb_pop({7'b0000000, treset});

        // TC/TD source
        host_wr(3'd1, 8'hA5);
        host_wr(3'd0, 8'h3C);
        sb_push("td_byte", 8'hA5);
        sb_push("td_par", {7'b0000000, ^8'hA5});
        tx_frame(1'b1, b, p);
        sb_pop(b);
        sb_pop({7'b0000000, p});
        sb_push("tc_byte", 8'h3C);
        sb_push("tc_par", {7'b0000000, ^8'h3C});
        tx_frame(1'b0, b, p);
        sb_pop(b);
        sb_pop({7'b0000000, p});
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        check_reg("status_sent", 3'd4, 8'h30);
        host_wr(3'd4, 8'h30);
        check_reg("status_sent_clr", 3'd4, 8'h00);

        // RC/RD capture
        rx_byte_checked("rd_par", 1'b1, 8'h81);
        pulse(1'b0, 1'b1, 1'b1, 1'b0);
        rx_byte_checked("rc_par", 1'b0, 8'h7E);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check_reg("rd_capture", 3'd3, 8'h81);
        check_reg("rc_capture", 3'd2, 8'h7E);
        check_reg("status_new", 3'd4, 8'hC0);
        host_wr(3'd4, 8'hC0);
        check_reg("status_new_clr", 3'd4, 8'h00);

        // Parity output latency for 0x80, then 0x03 as a resend
        rx_bits(1'b0, 8'h80, 7);
        rt = 1'b0; le = 1'b0; dc = 1'b0; dout = 1'b0;
        repeat (2) @(negedge clk);
        tclk = 1'b1;
        repeat (2) @(negedge clk);
        check_din("par_lat2", 1'b0);
        @(negedge clk);
        check_din("par_lat3", 1'b1);
        repeat (3) @(negedge clk);
        tclk = 1'b0;
        repeat (4) @(negedge clk);
        rx_byte_checked("par_03", 1'b0, 8'h03);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check_reg("rc_03", 3'd2, 8'h03);
        check_reg("status_rc03", 3'd4, 8'h80);
        host_wr(3'd4, 8'h80);

        // Retry: second byte replaces the first, one commit only
        rx_bits(1'b1, 8'h55, 8);
        rx_bits(1'b1, 8'h5A, 8);
        check_reg("retry_no_commit", 3'd4, 8'h00);
        pulse(1'b0, 1'b1, 1'b1, 1'b0);
        check_reg("retry_rd", 3'd3, 8'h5A);
        check_reg("retry_status", 3'd4, 8'h40);
        host_wr(3'd4, 8'h40);
        pulse(1'b0, 1'b1, 1'b1, 1'b0);
        check_reg("retry_single", 3'd4, 8'h00);

        // Abort: partial receive byte, then a TD frame starts
        rx_bits(1'b0, 8'hF0, 5);
        pulse(1'b1, 1'b1, 1'b1, 1'b0);
        check_din("abort_din", 1'b0);
        b = 8'h00;
        sb_push("abort_td", 8'hA5);
        for (int i = 0; i < 8; i++) begin
            pulse(1'b1, 1'b0, 1'b1, 1'b0);
            b = {b[6:0], din};
        end
        sb_pop(b);
        check_reg("abort_rc", 3'd2, 8'h03);
        check_reg("abort_rd", 3'd3, 8'h5A);

        // treset register and asynchronous reset mid-frame
        @(negedge clk);
        host_if.adr = 3'd4; host_if.d = 8'h08; host_if.cs = 1'b1; host_if.we = 1'b1;
        sb_push("treset_before", 8'h00);
        sb_pop({7'b0000000, treset});
        @(negedge clk);
        host_if.cs = 1'b0; host_if.we = 1'b0;
        sb_push("treset_set", 8'h01);
        sb_pop({7'b0000000, treset});
        pulse(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, 1'b1, 1'b0);
        check_din("mid_din", 1'b1);
        rt = 1'b1; le = 1'b0; dc = 1'b1; dout = 1'b0;
        repeat (2) @(negedge clk);
        tclk = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_din("rst_din", 1'b0);
        sb_push("rst_treset", 8'h00);
        sb_pop({7'b0000000, treset});
        tclk = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_reg("rst_td", 3'd1, 8'h00);
        sb_push("post_rst_td", 8'h00);
        sb_push("post_rst_par", 8'h00);
        tx_frame(1'b1, b, p);
        sb_pop(b);
        sb_pop({7'b0000000, p});

        if (sb_q.size() != 0) chk("sb_leftover", 8'(sb_q.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
